// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between fetch and data.
// Data wins ties; a saturating counter bounds how long fetch can starve.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    output logic                    o_if_gnt,
    output logic                    o_if_rvalid,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    input  logic                    i_dm_req,
    input  logic                    i_dm_we,
    input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
    input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_dm_be,
    output logic                    o_dm_gnt,
    output logic                    o_dm_rvalid,
    output logic [DATA_WIDTH-1:0]   o_dm_rdata,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    input  logic                    i_mem_gnt,
    input  logic                    i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   starve_q, starve_d;
    logic                   owner_dm_q, owner_dm_d;
    logic                   hold_we_q, hold_we_d;
    logic [ADDR_WIDTH-1:0]  hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0]  hold_wdata_q, hold_wdata_d;
    logic [BE_WIDTH-1:0]    hold_be_q, hold_be_d;

    logic if_win;
    logic dm_win;
    logic mem_active;
    logic rsp_fire;

    // Pick a winner while idle; fetch only beats data once it has starved.
    always_comb begin
        if_win = 1'b0;
        dm_win = 1'b0;
        if (i_arst_n && state_q == IDLE) begin
            if (i_dm_req && (!i_if_req || starve_q < LIMIT)) begin
                dm_win = 1'b1;
            end else if (i_if_req) begin
                if_win = 1'b1;
            end
        end
    end

    // Next state, payload capture and starvation bookkeeping.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        owner_dm_d   = owner_dm_q;
        hold_we_d    = hold_we_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_be_d    = hold_be_q;
        unique case (state_q)
            IDLE: begin
                if (dm_win) begin
                    state_d      = REQ;
                    owner_dm_d   = 1'b1;
                    hold_we_d    = i_dm_we;
                    hold_addr_d  = i_dm_addr;
                    hold_wdata_d = i_dm_wdata;
                    hold_be_d    = i_dm_be;
                    if (!i_if_req) begin
                        starve_d = '0;
                    end else if (starve_q != LIMIT) begin
                        starve_d = starve_q + CNT_WIDTH'(1);
                    end
                end else if (if_win) begin
                    state_d      = REQ;
                    owner_dm_d   = 1'b0;
                    hold_we_d    = 1'b0;
                    hold_addr_d  = i_if_addr;
                    hold_wdata_d = '0;
                    hold_be_d    = '1;
                    starve_d     = '0;
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and holding registers; reset abandons any in-flight access.
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            owner_dm_q   <= 1'b0;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_be_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            owner_dm_q   <= owner_dm_d;
            hold_we_q    <= hold_we_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_be_q    <= hold_be_d;
        end
    end

    // Drive the memory port and route the response to its owner.
    always_comb begin
        mem_active  = i_arst_n && state_q == REQ;
        rsp_fire    = i_arst_n && state_q == RESP && i_mem_rvalid;
        o_if_gnt    = if_win;
        o_dm_gnt    = dm_win;
        o_mem_req   = mem_active;
        o_mem_we    = mem_active && hold_we_q;
        o_mem_addr  = mem_active ? hold_addr_q : '0;
        o_mem_wdata = mem_active ? hold_wdata_q : '0;
        o_mem_be    = mem_active ? hold_be_q : '0;
        o_if_rvalid = rsp_fire && !owner_dm_q;
        o_dm_rvalid = rsp_fire && owner_dm_q;
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
        o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed traffic against a transaction
// model; expectations are queued by the driver and consumed by a monitor.
module tb_mem_port_arbiter;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int BW    = DW / 8;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr_in, dm_addr_in;
    logic [DW-1:0] dm_wdata_in;
    logic [BW-1:0] dm_be_in;
    logic          mem_gnt, mem_rvalid;
    logic [DW-1:0] mem_rdata;

    logic          o_if_gnt, o_if_rvalid, o_dm_gnt, o_dm_rvalid;
    logic [DW-1:0] o_if_rdata, o_dm_rdata, o_mem_wdata;
    logic          o_mem_req, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [BW-1:0] o_mem_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .i_clk(clk), .i_arst_n(arst_n),
        .i_if_req(if_req), .i_if_addr(if_addr_in),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid),
        .o_if_rdata(o_if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr_in),
        .i_dm_wdata(dm_wdata_in), .i_dm_be(dm_be_in),
        .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid),
        .o_dm_rdata(o_dm_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_be(o_mem_be),
        .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid),
        .i_mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } mreq_t;

    typedef struct {
        bit            dm;
        bit            cmp_data;
        logic [DW-1:0] data;
    } rsp_t;

    bit    gnt_q[$];
    bit    busy_q[$];
    mreq_t mem_q[$];
    rsp_t  rsp_q[$];
    bit    dut_gnt_log[$];

    int checks = 0;
    int passed = 0;

    // Transaction-level model: who is waiting, what is outstanding.
    bit            if_pend, dm_pend;
    logic [AW-1:0] if_addr, dm_addr;
    logic          dm_st;
    logic [DW-1:0] dm_wdata;
    logic [BW-1:0] dm_be;
    int            phase;
    int            streak;
    bit            owner_dm;
    bit            owner_we;

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Monitor: consume expectations whenever the DUT shows activity.
    initial begin
        rsp_t  r;
        mreq_t m;
        logic  any_out;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                any_out = o_if_gnt | o_if_rvalid | (|o_if_rdata) |
                          o_dm_gnt | o_dm_rvalid | (|o_dm_rdata) |
                          o_mem_req | o_mem_we | (|o_mem_addr) |
                          (|o_mem_wdata) | (|o_mem_be);
                chk("reset_outputs", 64'(any_out), 64'd0);
                continue;
            end
            if (busy_q.size() == 0) chk("busy_underflow", 1, 0);
            else chk("mem_req", 64'(o_mem_req), 64'(busy_q.pop_front()));

            if (o_if_gnt && o_dm_gnt) chk("double_gnt", 1, 0);
            if (o_if_gnt || o_dm_gnt) begin
                dut_gnt_log.push_back(o_dm_gnt);
                if (o_mem_req) chk("gnt_with_mem_req", 1, 0);
                if (gnt_q.size() == 0) chk("spurious_gnt", 1, 0);
                else chk("gnt_is_dm", 64'(o_dm_gnt), 64'(gnt_q.pop_front()));
            end else if (gnt_q.size() != 0) begin
                void'(gnt_q.pop_front());
                chk("missing_gnt", 0, 1);
            end

            if (o_mem_req) begin
                if (mem_q.size() == 0) begin
                    chk("spurious_mem_req", 1, 0);
                end else begin
                    m = mem_q[0];
                    chk("mem_addr", o_mem_addr, m.addr);
                    chk("mem_we", 64'(o_mem_we), 64'(m.we));
                    chk("mem_be", 64'(o_mem_be), 64'(m.be));
                    if (m.we) chk("mem_wdata", o_mem_wdata, m.wdata);
                    if (mem_gnt) void'(mem_q.pop_front());
                end
            end

            if (o_if_rvalid && o_dm_rvalid) chk("double_rvalid", 1, 0);
            if (o_if_rvalid || o_dm_rvalid) begin
                if (rsp_q.size() == 0) begin
                    chk("spurious_rvalid", 1, 0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rvalid_is_dm", 64'(o_dm_rvalid), 64'(r.dm));
                    if (r.dm) begin
                        chk("if_rdata_idle", o_if_rdata, 0);
                        if (r.cmp_data) chk("dm_rdata", o_dm_rdata, r.data);
                    end else begin
                        chk("if_rdata", o_if_rdata, r.data);
                        chk("dm_rdata_idle", o_dm_rdata, 0);
                    end
                end
            end else begin
                if (rsp_q.size() != 0) begin
                    void'(rsp_q.pop_front());
                    chk("missing_rvalid", 0, 1);
                end
                chk("rdata_idle", o_if_rdata | o_dm_rdata, 0);
            end
        end
    end

    task automatic drive();
        if (!if_pend) if_addr = rnd64();
        if (!dm_pend) begin
            dm_addr  = rnd64();
            dm_wdata = rnd64();
            dm_be    = BW'($urandom);
            dm_st    = $urandom_range(0, 1) == 1;
        end
        if_req      = if_pend;
        if_addr_in  = if_addr;
        dm_req      = dm_pend;
        dm_we       = dm_st;
        dm_addr_in  = dm_addr;
        dm_wdata_in = dm_wdata;
        dm_be_in    = dm_be;
    endtask

    // Advance the model by one cycle using the inputs now driven.
    task automatic step();
        bit take_dm;
        if (!arst_n) begin
            phase  = 0;
            streak = 0;
            mem_q.delete();
        end else begin
            busy_q.push_back(phase == 1);
            case (phase)
                0: if (if_pend || dm_pend) begin
                    take_dm = dm_pend && (!if_pend || streak < LIMIT);
                    gnt_q.push_back(take_dm);
                    owner_dm = take_dm;
                    if (take_dm) begin
                        streak   = if_pend ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
                        owner_we = dm_st;
                        mem_q.push_back('{dm_addr, dm_st, dm_wdata, dm_be});
                        dm_pend  = 0;
                    end else begin
                        streak   = 0;
                        owner_we = 0;
                        mem_q.push_back('{if_addr, 1'b0, '0, '1});
                        if_pend  = 0;
                    end
                    phase = 1;
                end
                1: if (mem_gnt) phase = 2;
                2: if (mem_rvalid) begin
                    rsp_q.push_back('{owner_dm, !(owner_dm && owner_we), mem_rdata});
                    phase = 0;
                end
                default: phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n, logic [31:0] gp, logic [31:0] rp, logic [DW-1:0] rd);
        for (int i = 0; i < n; i++) begin
            drive();
            mem_gnt    = gp[i];
            mem_rvalid = rp[i];
            mem_rdata  = rd;
            step();
        end
    endtask

    initial begin
        phase = 0; streak = 0; owner_dm = 0; owner_we = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        arst_n = 0;
        if_pend = 1; dm_pend = 1;
        drive();
        // Reset held with both requests asserted.
        repeat (2) begin drive(); step(); end
        arst_n = 1;

        // Both requesters saturate the port; memory answers at full speed.
        dut_gnt_log.delete();
        for (int i = 0; i < 31; i++) begin
            if_pend = 1;
            if (!dm_pend) begin dm_pend = 1; end
            drive();
            if (!if_pend) if_pend = 1;
            mem_gnt = 1; mem_rvalid = 1; mem_rdata = rnd64();
            step();
            if (!if_pend) if_pend = 1;
            if (!dm_pend) dm_pend = 1;
        end
        if (dut_gnt_log.size() < 10) begin
            chk("starve_seq_len", 64'(dut_gnt_log.size()), 10);
        end else begin
            for (int i = 0; i < 10; i++)
                chk($sformatf("starve_seq[%0d]", i),
                    64'(dut_gnt_log[i]), 64'((i % 5) != 4));
        end
        run(12, '1, '1, 64'h1234);

        // Single fetch, with stray responses in IDLE and REQ.
        if_pend = 1; if_addr = 64'h1000;
        run(4, 32'b0010, 32'b1011, 64'hDEAD_BEEF);
        run(2, 0, 32'b01, 64'h5);

        // Store held across three stalled grant cycles.
        dm_pend = 1; dm_st = 1; dm_addr = 64'h2008;
        dm_wdata = 64'h55; dm_be = 8'h0F;
        run(6, 32'b010000, 32'b100100, 64'h77);

        // Reset while waiting for the response; late response is dropped.
        if_pend = 1; if_addr = 64'h3000;
        run(3, 32'b010, 32'b000, 64'h9);
        arst_n = 0; drive(); step(); arst_n = 1;
        run(1, 0, 1, 64'hBAD);
        dm_pend = 1; dm_st = 0; dm_addr = 64'h4000;
        run(3, 32'b010, 32'b100, 64'hCAFE);

        // Random traffic with stalls, stray responses and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_addr = rnd64();
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend = 1; dm_addr = rnd64(); dm_wdata = rnd64();
                dm_be = BW'($urandom); dm_st = $urandom_range(0, 1) == 1;
            end
            arst_n = $urandom_range(0, 199) != 0;
            drive();
            mem_gnt    = $urandom_range(0, 1) == 1;
            mem_rvalid = $urandom_range(0, 1) == 1;
            mem_rdata  = rnd64();
            step();
        end
        arst_n = 1;
        run(12, '1, '1, 64'h42);

        chk("drain_gnt", 64'(gnt_q.size()), 0);
        chk("drain_rsp", 64'(rsp_q.size()), 0);
        chk("drain_mem", 64'(mem_q.size()), 0);
        chk("model_idle", 64'(if_pend | dm_pend), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the core's single memory port between instruction fetch (IF) and the data-memory stage (DM, loads/stores). It sits between the pipeline and the memory subsystem. It captures one request at a time, drives the memory request/grant handshake, and routes the response back to the owner. Data has priority, and a starvation counter bounds how long fetch can wait.

## Interface
Reset is synchronous and active-low.

Parameters:
- ADDR_WIDTH, 64, address width of all ports
- DATA_WIDTH, 64, data width; byte-enable width is DATA_WIDTH/8
- STARVE_LIMIT, 4, number of consecutive DM grants with IF pending before IF is forced to win (≥1)

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  reset; synchronous, active-low, sampled on rising i_clk
- i_if_req  in  1  fetch request, held until o_if_gnt
- i_if_addr  in  ADDR_WIDTH  fetch address
- o_if_gnt  out  1  one-cycle pulse: IF request captured
- o_if_rvalid  out  1  one-cycle pulse: fetch data valid
- o_if_rdata  out  DATA_WIDTH  fetch data
- i_dm_req  in  1  data request, held until o_dm_gnt
- i_dm_we  in  1  1 = store, 0 = load
- i_dm_addr  in  ADDR_WIDTH  data address
- i_dm_wdata  in  DATA_WIDTH  store data
- i_dm_be  in  DATA_WIDTH/8  store byte enables
- o_dm_gnt  out  1  one-cycle pulse: DM request captured
- o_dm_rvalid  out  1  one-cycle pulse: load data or store acknowledge
- o_dm_rdata  out  DATA_WIDTH  load data
- o_mem_req  out  1  memory request
- o_mem_we  out  1  memory write
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_wdata  out  DATA_WIDTH  memory write data
- o_mem_be  out  DATA_WIDTH/8  memory byte enables; all ones for IF
- i_mem_gnt  in  1  memory accepted request
- i_mem_rvalid  in  1  memory response; one per accepted request, reads and writes alike
- i_mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- **FSM states:** IDLE, REQ, RESP. Exactly one transaction is outstanding.
- **IDLE:**
  - If any request is present, select a winner, capture its payload into holding registers, pulse that requester's gnt, set the owner flag, and go to REQ.
  - With no request, stay in IDLE.
- **Arbitration:**
  - Only DM requesting → DM. Only IF requesting → IF.
  - Both requesting: DM wins if starve_cnt < STARVE_LIMIT, otherwise IF wins.
- **starve_cnt:**
  - Width is clog2(STARVE_LIMIT+1); it saturates.
  - Increments on a DM grant while i_if_req = 1.
  - Clears to 0 on any IF grant, and on a DM grant while i_if_req = 0.
- **REQ:**
  - o_mem_req = 1 and the o_mem_* fields come from the holding registers, stable until granted.
  - On i_mem_gnt = 1, go to RESP. i_mem_rvalid is ignored in REQ.
- **RESP:**
  - o_mem_req = 0. On i_mem_rvalid = 1, route the response to the owner in the same cycle (combinational), then go to IDLE.
  - If owner = IF: o_if_rvalid = 1, o_if_rdata = i_mem_rdata.
  - If owner = DM: o_dm_rvalid = 1, o_dm_rdata = i_mem_rdata (don't-care for stores).
- **Idle outputs:** o_*_rdata is 0 whenever the matching rvalid is 0. i_mem_rvalid in IDLE is ignored.
- **Requests in flight:** requests arriving while in REQ/RESP are not captured; requesters keep i_*_req high.
- **Reset mid-operation:** any in-flight transaction is abandoned and no rvalid is forwarded. A late memory response arriving after reset is dropped, because it lands in IDLE.

## Timing
- **Reset values:** state IDLE, starve_cnt 0, holding registers 0, owner IF. All outputs 0: every gnt, rvalid, o_mem_req, o_mem_we, address, data and be.
- **Grant:** o_*_gnt is asserted combinationally in IDLE in cycle t, the same cycle the request is sampled. o_mem_req rises in t+1.
- **Best-case round trip:**
  - t: grant.
  - t+1: o_mem_req with i_mem_gnt.
  - t+2: i_mem_rvalid, and the owner's rvalid in the same cycle.
  - t+3: IDLE, earliest next grant.
  - Peak throughput is therefore one transaction per 3 cycles.
- **Memory stalls:** each cycle i_mem_gnt is low holds REQ one more cycle. Each cycle i_mem_rvalid is low holds RESP one more cycle. There is no timeout.
- **No overlap:** at most one gnt pulse per cycle, and gnt never coincides with o_mem_req = 1.

## Test plan
- **Reset values:** hold i_arst_n = 0 for 2 cycles with both requests high → all outputs 0. Release reset → DM granted in the first cycle.
- **Single IF read:** IF addr 0x1000, memory gnt 1 cycle after req, rvalid 2 cycles later with rdata 0xDEADBEEF → o_if_gnt at t, o_mem_addr = 0x1000 with be = all ones, o_if_rvalid with 0xDEADBEEF at t+3, o_dm_rvalid never asserted.
- **Store:** DM store, addr 0x2008, wdata 0x55, be 0x0F → o_mem_we = 1 and payload stable across 3 stalled gnt cycles, o_dm_rvalid on the ack.
- **Starvation limit:** both requests held continuously, STARVE_LIMIT = 4 → grant sequence DM, DM, DM, DM, IF, DM, DM, DM, DM, IF.
- **Reset mid-RESP:** assert i_arst_n = 0 during RESP, then deliver i_mem_rvalid after reset release → no o_*_rvalid, state IDLE, next request granted normally.
- **Stray response:** i_mem_rvalid pulsed in IDLE and in REQ → ignored, no rvalid forwarded, FSM state unchanged.
